// File: rtl/qbus_responder.sv
// qbus_responder: Q-bus style slave placed after the CPU bus sequencer.
//   Decodes RAM / ROM / unmapped regions, inserts WAIT_STATES wait states,
//   runs one access on an external synchronous memory port, then returns
//   RPLY (or a one-cycle error_o pulse after TIMEOUT cycles when the address
//   is unmapped). All state advances only on ce-qualified clocks.
// Ports:
//   clk, reset_n (async, active low), ce
//   SYNC/DIN/DOUT/WTBT, addr_i, wdata_i   - CPU side bus controls and data
//   rdata_o, RPLY, error_o                - back to the CPU
//   mem_addr/mem_wdata/mem_we/mem_be      - memory request (word addressed)
//   mem_rdata                             - memory read data (1 cycle latency)
//   sel1_o/sel2_o                         - only with SEL_REGS_EN
// Optional feature: define SEL_REGS_EN to add the SEL1 (177716, read-only
// constant 000200) and SEL2 (177714, read/write word) internal registers.
module qbus_responder #(
    parameter logic [15:0] RAM_TOP     = 16'o100000,
    parameter logic [15:0] ROM_TOP     = 16'o177600,
    parameter int          WAIT_STATES = 2,
    parameter int          TIMEOUT     = 63
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        SYNC,
    input  logic        DIN,
    input  logic        DOUT,
    input  logic        WTBT,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        RPLY,
    output logic        error_o,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    input  logic [15:0] mem_rdata
`ifdef SEL_REGS_EN
    ,
    output logic        sel1_o,
    output logic        sel2_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACC, S_REPLY, S_DONE, S_TOUT
    } state_t;

    state_t      state, state_nxt;
    logic        syncd;
    logic [7:0]  cnt;
    logic        wtbt_q, a0_q, ram_q;
    logic        start, strobe, rd, wr;
    logic        hit_ram, hit_rom, hit_any;

    assign start  = SYNC & ~syncd;
    assign strobe = DIN | DOUT;
    assign rd     = DIN;
    assign wr     = DOUT & ~DIN;   // DIN wins when both strobes are high

    assign hit_ram = (addr_i < RAM_TOP);
    assign hit_rom = (addr_i >= RAM_TOP) && (addr_i < ROM_TOP);

`ifdef SEL_REGS_EN
    localparam logic [15:0] SEL1_ADDR = 16'o177716;
    localparam logic [15:0] SEL2_ADDR = 16'o177714;
    localparam logic [15:0] SEL1_VAL  = 16'o000200;

    logic        hit_sel1, hit_sel2, sel1_q, sel2_q;
    logic [15:0] sel2_reg;

    // word compare: byte address bit 0 does not matter
    assign hit_sel1 = (addr_i[15:1] == SEL1_ADDR[15:1]);
    assign hit_sel2 = (addr_i[15:1] == SEL2_ADDR[15:1]);
    assign hit_any  = hit_ram | hit_rom | hit_sel1 | hit_sel2;
`else
    assign hit_any  = hit_ram | hit_rom;
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else if (ce)
            state <= state_nxt;
    end

    // next state; SYNC low anywhere past IDLE abandons the access
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = hit_any ? S_WAIT : S_TOUT;
            S_WAIT:  if (!SYNC) state_nxt = S_IDLE;
                     else if (strobe && cnt == 8'd0) state_nxt = S_ACC;
            S_ACC:   state_nxt = SYNC ? S_REPLY : S_IDLE;
            S_REPLY: if (!SYNC) state_nxt = S_IDLE;
                     else if (!strobe) state_nxt = S_DONE;
            S_DONE:  if (!SYNC) state_nxt = S_IDLE;
            S_TOUT:  if (!SYNC) state_nxt = S_IDLE;
                     else if (cnt == 8'd0) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs; mem_we is decoded from state so an abort or reset drops it at once
    always_comb begin
        RPLY    = (state == S_REPLY);
        error_o = (state == S_TOUT) && (cnt == 8'd0);
        mem_we  = (state == S_ACC) && SYNC && wr && ram_q;
        mem_be  = 2'b00;
        if (mem_we)
            mem_be = wtbt_q ? (a0_q ? 2'b10 : 2'b01) : 2'b11;
    end

`ifdef SEL_REGS_EN
    assign sel1_o = sel1_q && (state == S_WAIT || state == S_ACC || state == S_REPLY);
    assign sel2_o = sel2_q && (state == S_WAIT || state == S_ACC || state == S_REPLY);
`endif

    // datapath: access latches, wait/timeout counter, read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncd     <= 1'b0;
            cnt       <= 8'd0;
            wtbt_q    <= 1'b0;
            a0_q      <= 1'b0;
            ram_q     <= 1'b0;
            mem_addr  <= 15'd0;
            mem_wdata <= 16'd0;
            rdata_o   <= 16'd0;
`ifdef SEL_REGS_EN
            sel1_q    <= 1'b0;
            sel2_q    <= 1'b0;
            sel2_reg  <= 16'd0;
`endif
        end else if (ce) begin
            syncd <= SYNC;
            case (state)
                S_IDLE: if (start) begin
                    mem_addr <= addr_i[15:1];
                    wtbt_q   <= WTBT;
                    a0_q     <= addr_i[0];
                    ram_q    <= hit_ram;
                    cnt      <= hit_any ? 8'(WAIT_STATES) : 8'(TIMEOUT);
`ifdef SEL_REGS_EN
                    sel1_q   <= hit_sel1;
                    sel2_q   <= hit_sel2;
                    if (hit_sel1 || hit_sel2)
                        cnt <= 8'd0;   // internal registers reply without wait states
`endif
                end
                // counter runs only once a strobe is seen; saturates at zero
                S_WAIT: if (SYNC && strobe) begin
                    if (cnt != 8'd0)
                        cnt <= cnt - 8'd1;
                    else if (wr)
                        mem_wdata <= wdata_i;
                end
                S_ACC: if (SYNC) begin
                    if (rd) begin
`ifdef SEL_REGS_EN
                        if (sel1_q)
                            rdata_o <= SEL1_VAL;
                        else if (sel2_q)
                            rdata_o <= sel2_reg;
                        else
                            rdata_o <= mem_rdata;
`else
                        rdata_o <= mem_rdata;
`endif
                    end
`ifdef SEL_REGS_EN
                    else if (wr && sel2_q)
                        sel2_reg <= mem_wdata;
`endif
                end
                S_TOUT: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_responder.sv
module tb_qbus_responder;

    logic        clk = 1'b0;
    logic        reset_n, ce, SYNC, DIN, DOUT, WTBT;
    logic [15:0] addr_i, wdata_i, rdata_o, mem_wdata, mem_rdata;
    logic        RPLY, error_o, mem_we;
    logic [14:0] mem_addr;
    logic [1:0]  mem_be;
`ifdef SEL_REGS_EN
    logic        sel1_o, sel2_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qbus_responder #(
        .RAM_TOP(16'o100000), .ROM_TOP(16'o177600), .WAIT_STATES(2), .TIMEOUT(63)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .RPLY(RPLY), .error_o(error_o),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
`ifdef SEL_REGS_EN
        , .sel1_o(sel1_o), .sel2_o(sel2_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    // one clock; inputs change and outputs are sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [15:0] a, input logic w);
        addr_i = a;
        WTBT   = w;
        SYNC   = 1'b1;
        tick();
    endtask

    task automatic finish_access();
        DIN  = 1'b0;
        DOUT = 1'b0;
        tick();
        SYNC = 1'b0;
        tick();
    endtask

    // n = edges until RPLY seen (99 if never); also records write strobes
    task automatic run_to_rply(output int n, output int we_cnt, output logic [1:0] be,
                               output logic [14:0] a, output logic [15:0] wd);
        n = 99; we_cnt = 0; be = 2'bxx; a = 'x; wd = 'x;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (mem_we) begin
                we_cnt++; be = mem_be; a = mem_addr; wd = mem_wdata;
            end
            if (RPLY) begin
                n = i;
                break;
            end
        end
    endtask

    // n = edges until error_o seen (999 if never); flags any RPLY on the way
    task automatic run_to_err(output int n, output logic saw_rply);
        n = 999; saw_rply = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (RPLY) saw_rply = 1'b1;
            if (error_o) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int          n, we_cnt;
        logic [1:0]  be;
        logic [14:0] a;
        logic [15:0] wd;
        logic        saw;

        reset_n = 1'b0; ce = 1'b1; SYNC = 1'b0; DIN = 1'b0; DOUT = 1'b0; WTBT = 1'b0;
        addr_i = '0; wdata_i = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_rply", RPLY, 0);
        check("rst_err", error_o, 0);
        check("rst_we", mem_we, 0);
        check("rst_be", mem_be, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mwdata", mem_wdata, 0);
        reset_n = 1'b1;
        tick();

        // word read, 2 wait states
        mem_rdata = 16'o123456;
        start(16'o001000, 1'b0);
        check("rd_maddr", mem_addr, 15'o000400);
        check("rd_rply_early", RPLY, 0);
        DIN = 1'b1;
        run_to_rply(n, we_cnt, be, a, wd);
        check("rd_lat", n, 4);
        check("rd_we", we_cnt, 0);
        check("rd_data", rdata_o, 16'o123456);
        tick();
        check("rd_rply_hold", RPLY, 1);
        DIN = 1'b0;
        tick();
        check("rd_rply_drop", RPLY, 0);
        SYNC = 1'b0;
        tick();

        // byte write, odd address -> high lane
        start(16'o001001, 1'b1);
        DOUT = 1'b1; wdata_i = 16'o052400;
        run_to_rply(n, we_cnt, be, a, wd);
        check("wb_rply_lat", n, 4);
        check("wb_we_cnt", we_cnt, 1);
        check("wb_be", be, 2'b10);
        check("wb_addr", a, 15'o000400);
        check("wb_wdata", wd, 16'o052400);
        check("wb_rdata_hold", rdata_o, 16'o123456);
        finish_access();

        // word write at odd address: whole word at addr[15:1]
        start(16'o002003, 1'b0);
        DOUT = 1'b1; wdata_i = 16'o011111;
        run_to_rply(n, we_cnt, be, a, wd);
        check("ww_we_cnt", we_cnt, 1);
        check("ww_be", be, 2'b11);
        check("ww_addr", a, 15'o001001);
        finish_access();

        // byte write, even address -> low lane
        start(16'o003000, 1'b1);
        DOUT = 1'b1; wdata_i = 16'o000125;
        run_to_rply(n, we_cnt, be, a, wd);
        check("wbl_be", be, 2'b01);
        finish_access();

        // ROM write: acknowledged, dropped
        start(16'o120000, 1'b0);
        DOUT = 1'b1; wdata_i = 16'o177777;
        run_to_rply(n, we_cnt, be, a, wd);
        check("rom_rply_lat", n, 4);
        check("rom_we", we_cnt, 0);
        finish_access();

        // DIN and DOUT together behave as a read
        mem_rdata = 16'o070707;
        start(16'o001000, 1'b0);
        DIN = 1'b1; DOUT = 1'b1;
        run_to_rply(n, we_cnt, be, a, wd);
        check("both_we", we_cnt, 0);
        check("both_rdata", rdata_o, 16'o070707);
        finish_access();

        // unmapped read: timeout error, no RPLY
        start(16'o177650, 1'b0);
        DIN = 1'b1;
        run_to_err(n, saw);
        check("tout_lat", n, 63);
        check("tout_rply", saw, 0);
        tick();
        check("tout_err_width", error_o, 0);
        check("tout_rply_after", RPLY, 0);
        finish_access();

        // SYNC dropped during WAIT on a write
        start(16'o001000, 1'b0);
        DOUT = 1'b1; wdata_i = 16'o177777;
        tick();
        SYNC = 1'b0; DOUT = 1'b0;
        we_cnt = 0; saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_we) we_cnt++;
            if (RPLY) saw = 1'b1;
        end
        check("abort_we", we_cnt, 0);
        check("abort_rply", saw, 0);
        mem_rdata = 16'o031415;
        start(16'o002000, 1'b0);
        DIN = 1'b1;
        run_to_rply(n, we_cnt, be, a, wd);
        check("post_abort_lat", n, 4);
        check("post_abort_data", rdata_o, 16'o031415);
        finish_access();

        // ce low freezes the access
        mem_rdata = 16'o000042;
        start(16'o000100, 1'b0);
        ce = 1'b0; DIN = 1'b1;
        repeat (6) tick();
        check("ce_stall_rply", RPLY, 0);
        check("ce_stall_data", rdata_o, 16'o031415);
        ce = 1'b1;
        run_to_rply(n, we_cnt, be, a, wd);
        check("ce_lat", n, 4);
        check("ce_data", rdata_o, 16'o000042);
        finish_access();

`ifdef SEL_REGS_EN
        start(16'o177714, 1'b0);
        check("sel2_w_on", sel2_o, 1);
        check("sel1_w_off", sel1_o, 0);
        DOUT = 1'b1; wdata_i = 16'o000777;
        run_to_rply(n, we_cnt, be, a, wd);
        check("sel2_w_lat", n, 2);
        check("sel2_w_we", we_cnt, 0);
        check("sel2_w_hold", sel2_o, 1);
        finish_access();
        check("sel2_off_idle", sel2_o, 0);

        mem_rdata = 16'o111111;
        start(16'o177714, 1'b0);
        check("sel2_r_on", sel2_o, 1);
        DIN = 1'b1;
        run_to_rply(n, we_cnt, be, a, wd);
        check("sel2_r_lat", n, 2);
        check("sel2_r_data", rdata_o, 16'o000777);
        check("sel2_r_hold", sel2_o, 1);
        finish_access();

        start(16'o177716, 1'b0);
        check("sel1_r_on", sel1_o, 1);
        DIN = 1'b1;
        run_to_rply(n, we_cnt, be, a, wd);
        check("sel1_r_data", rdata_o, 16'o000200);
        finish_access();
`else
        // without the option the SEL2 address is just unmapped
        start(16'o177714, 1'b0);
        DIN = 1'b1;
        run_to_err(n, saw);
        check("sel2_tout_lat", n, 63);
        check("sel2_tout_rply", saw, 0);
        finish_access();
`endif

        // asynchronous reset in the middle of a write strobe
        start(16'o001000, 1'b0);
        DOUT = 1'b1; wdata_i = 16'o123123;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_we) begin
                saw = 1'b1;
                break;
            end
        end
        check("arst_we_pre", saw, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_we", mem_we, 0);
        check("arst_rply", RPLY, 0);
        check("arst_maddr", mem_addr, 0);
        check("arst_mwdata", mem_wdata, 0);
        check("arst_rdata", rdata_o, 0);
        @(negedge clk);
        SYNC = 1'b0; DOUT = 1'b0;
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
